// File: rtl/uart_mat_mul_pkg.sv
// Shared types and constants for the UART + 2x2 matrix-multiply datapath.
//   rx_state_t / tx_state_t : UART receiver / transmitter FSM encodings
//   CLKS_PER_BIT_DEF        : default bit period in clk cycles (12 MHz / 115200)
//   DATA_W                  : byte and matrix element width
//   mac8                    : low byte of a 2-term unsigned dot product
package uart_mat_mul_pkg;

   localparam int CLKS_PER_BIT_DEF = 104;
   localparam int DATA_W           = 8;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_t;

   // Full-width 16-bit products and 17-bit sum; only the low byte is kept.
   function automatic logic [DATA_W-1:0] mac8(
      input logic [DATA_W-1:0] x0,
      input logic [DATA_W-1:0] y0,
      input logic [DATA_W-1:0] x1,
      input logic [DATA_W-1:0] y1
   );
      logic [2*DATA_W-1:0] p0;
      logic [2*DATA_W-1:0] p1;
      p0 = {{DATA_W{1'b0}}, x0} * {{DATA_W{1'b0}}, y0};
      p1 = {{DATA_W{1'b0}}, x1} * {{DATA_W{1'b0}}, y1};
      return DATA_W'({1'b0, p0} + {1'b0, p1});
   endfunction

endpackage

// File: rtl/uart_mat_mul_mat_mul_2x2.sv
// Registered 2x2 unsigned matrix multiplier, C = A*B, each element mod 256.
// Ports:
//   clk, rst_n          : clock, async active-low reset (C clears to 0)
//   a11..a22, b11..b22  : operand matrices, sampled every cycle
//   c11..c22            : product, one cycle after the operands
module mat_mul_2x2
   import uart_mat_mul_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] a11,
   input  logic [DATA_W-1:0] a12,
   input  logic [DATA_W-1:0] a21,
   input  logic [DATA_W-1:0] a22,
   input  logic [DATA_W-1:0] b11,
   input  logic [DATA_W-1:0] b12,
   input  logic [DATA_W-1:0] b21,
   input  logic [DATA_W-1:0] b22,
   output logic [DATA_W-1:0] c11,
   output logic [DATA_W-1:0] c12,
   output logic [DATA_W-1:0] c21,
   output logic [DATA_W-1:0] c22
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c11 <= '0;
         c12 <= '0;
         c21 <= '0;
         c22 <= '0;
      end else begin
         c11 <= mac8(a11, b11, a12, b21);
         c12 <= mac8(a11, b12, a12, b22);
         c21 <= mac8(a21, b11, a22, b21);
         c22 <= mac8(a21, b12, a22, b22);
      end
   end

endmodule

// File: rtl/uart_mat_mul.sv
// Serial I/O and compute datapath: 8N1 full-duplex UART plus registered
// 2x2 matrix multiplier.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   rx, rx_enable           : serial input (idle high), receiver enable level
//   rx_byte, byte_available : last good byte, one-cycle new-byte pulse
//   tx, tx_enable, tx_byte  : serial output (idle high), start strobe, byte
//   tx_busy                 : high for the whole 10-bit frame
//   a*, b*, c*              : matrix operands and registered product
//
// RX FSM
//   state    | meaning
//   RX_IDLE  | waiting for a falling edge on the synchronized line
//   RX_START | half-bit wait, confirm start bit still low
//   RX_DATA  | sampling 8 data bits LSB first, one per bit period
//   RX_STOP  | sampling stop bit; good stop publishes the byte
//
// TX FSM
//   state    | meaning
//   TX_IDLE  | line high, accepting tx_enable
//   TX_START | driving start bit
//   TX_DATA  | driving 8 data bits LSB first
//   TX_STOP  | driving stop bit, busy drops at its end
module uart_mat_mul
   import uart_mat_mul_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              rx,
   output logic              tx,
   input  logic              rx_enable,
   output logic [DATA_W-1:0] rx_byte,
   output logic              byte_available,
   input  logic              tx_enable,
   input  logic [DATA_W-1:0] tx_byte,
   output logic              tx_busy,
   input  logic [DATA_W-1:0] a11,
   input  logic [DATA_W-1:0] a12,
   input  logic [DATA_W-1:0] a21,
   input  logic [DATA_W-1:0] a22,
   input  logic [DATA_W-1:0] b11,
   input  logic [DATA_W-1:0] b12,
   input  logic [DATA_W-1:0] b21,
   input  logic [DATA_W-1:0] b22,
   output logic [DATA_W-1:0] c11,
   output logic [DATA_W-1:0] c12,
   output logic [DATA_W-1:0] c21,
   output logic [DATA_W-1:0] c22
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------
   // RX
   // ------------------------------------------------------------------
   logic              rx_s1;
   logic              rx_s2;
   logic              rx_prev;
   logic              rx_fall;
   rx_state_t         rx_state;
   logic [CNT_W-1:0]  rx_cnt;
   logic [2:0]        rx_bit_idx;
   logic [DATA_W-1:0] rx_shift;

   // Sync flops reset high so a line held idle does not look like an edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_prev <= rx_s2;
      end
   end

   // rx_prev tracks the line in every state, so an edge right after STOP
   // is seen in the first IDLE cycle (back-to-back frames).
   assign rx_fall = rx_prev & ~rx_s2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state       <= RX_IDLE;
         rx_cnt         <= '0;
         rx_bit_idx     <= '0;
         rx_shift       <= '0;
         rx_byte        <= '0;
         byte_available <= 1'b0;
      end else begin
         byte_available <= 1'b0;
         if (!rx_enable) begin
            rx_state <= RX_IDLE;
         end else begin
            case (rx_state)
               RX_IDLE: begin
                  if (rx_fall) begin
                     rx_state <= RX_START;
                     rx_cnt   <= CNT_HALF;
                  end
               end
               RX_START: begin
                  if (rx_cnt != '0) begin
                     rx_cnt <= rx_cnt - CNT_ONE;
                  end else if (!rx_s2) begin
                     rx_state   <= RX_DATA;
                     rx_cnt     <= CNT_FULL;
                     rx_bit_idx <= '0;
                  end else begin
                     rx_state <= RX_IDLE;
                  end
               end
               RX_DATA: begin
                  if (rx_cnt != '0) begin
                     rx_cnt <= rx_cnt - CNT_ONE;
                  end else begin
                     rx_shift <= {rx_s2, rx_shift[DATA_W-1:1]};
                     rx_cnt   <= CNT_FULL;
                     if (rx_bit_idx == 3'd7) begin
                        rx_state <= RX_STOP;
                     end else begin
                        rx_bit_idx <= rx_bit_idx + 3'd1;
                     end
                  end
               end
               RX_STOP: begin
                  if (rx_cnt != '0) begin
                     rx_cnt <= rx_cnt - CNT_ONE;
                  end else begin
                     if (rx_s2) begin
                        rx_byte        <= rx_shift;
                        byte_available <= 1'b1;
                     end
                     rx_state <= RX_IDLE;
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   // ------------------------------------------------------------------
   // TX
   // ------------------------------------------------------------------
   tx_state_t         tx_state;
   logic [CNT_W-1:0]  tx_cnt;
   logic [2:0]        tx_bit_idx;
   logic [DATA_W-1:0] tx_shift;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state   <= TX_IDLE;
         tx_cnt     <= '0;
         tx_bit_idx <= '0;
         tx_shift   <= '0;
         tx         <= 1'b1;
         tx_busy    <= 1'b0;
      end else begin
         case (tx_state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (tx_enable) begin
                  tx_shift <= tx_byte;
                  tx_busy  <= 1'b1;
                  tx       <= 1'b0;
                  tx_cnt   <= CNT_FULL;
                  tx_state <= TX_START;
               end
            end
            TX_START: begin
               if (tx_cnt != '0) begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end else begin
                  tx         <= tx_shift[0];
                  tx_cnt     <= CNT_FULL;
                  tx_bit_idx <= '0;
                  tx_state   <= TX_DATA;
               end
            end
            TX_DATA: begin
               if (tx_cnt != '0) begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end else begin
                  tx_cnt <= CNT_FULL;
                  if (tx_bit_idx == 3'd7) begin
                     tx       <= 1'b1;
                     tx_state <= TX_STOP;
                  end else begin
                     tx         <= tx_shift[1];
                     tx_shift   <= {1'b0, tx_shift[DATA_W-1:1]};
                     tx_bit_idx <= tx_bit_idx + 3'd1;
                  end
               end
            end
            TX_STOP: begin
               if (tx_cnt != '0) begin
                  tx_cnt <= tx_cnt - CNT_ONE;
               end else begin
                  tx_busy  <= 1'b0;
                  tx_state <= TX_IDLE;
               end
            end
            default: tx_state <= TX_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Multiplier
   // ------------------------------------------------------------------
   mat_mul_2x2 u_mat_mul (
      .clk   (clk),
      .rst_n (rst_n),
      .a11   (a11),
      .a12   (a12),
      .a21   (a21),
      .a22   (a22),
      .b11   (b11),
      .b12   (b12),
      .b21   (b21),
      .b22   (b22),
      .c11   (c11),
      .c12   (c12),
      .c21   (c21),
      .c22   (c22)
   );

endmodule

// File: tb/tb_uart_mat_mul.sv
// Directed bench for uart_mat_mul at CLKS_PER_BIT=4.
module tb_uart_mat_mul;

   localparam int CPB = 4;

   logic       clk;
   logic       rst_n;
   logic       rx;
   logic       tx;
   logic       rx_enable;
   logic [7:0] rx_byte;
   logic       byte_available;
   logic       tx_enable;
   logic [7:0] tx_byte;
   logic       tx_busy;
   logic [7:0] a11, a12, a21, a22;
   logic [7:0] b11, b12, b21, b22;
   logic [7:0] c11, c12, c21, c22;

   int total = 0;
   int bad   = 0;

   int         pulse_cnt = 0;
   logic [7:0] rx_log [8];

   uart_mat_mul #(.CLKS_PER_BIT(CPB)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .rx             (rx),
      .tx             (tx),
      .rx_enable      (rx_enable),
      .rx_byte        (rx_byte),
      .byte_available (byte_available),
      .tx_enable      (tx_enable),
      .tx_byte        (tx_byte),
      .tx_busy        (tx_busy),
      .a11            (a11),
      .a12            (a12),
      .a21            (a21),
      .a22            (a22),
      .b11            (b11),
      .b12            (b12),
      .b21            (b21),
      .b22            (b22),
      .c11            (c11),
      .c12            (c12),
      .c21            (c21),
      .c22            (c22)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A pulse wider than one cycle is counted twice and shows up as a
   // wrong pulse count.
   always @(negedge clk) begin
      if (rst_n && byte_available === 1'b1) begin
         if (pulse_cnt < 8) rx_log[pulse_cnt] = rx_byte;
         pulse_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Called at #1 after a posedge; returns at #1 after a posedge.
   task automatic send_rx(input logic [7:0] d, input logic stop);
      logic [9:0] f;
      f = {stop, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         rx = f[i];
         repeat (CPB) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tx_frame(input logic [7:0] d, input bit inject);
      logic [9:0] f;
      f = {1'b1, d, 1'b0};
      tx_byte   = d;
      tx_enable = 1'b1;
      @(posedge clk);
      #1;
      tx_enable = 1'b0;
      for (int k = 0; k < 10 * CPB; k++) begin
         check("tx_bit", {31'd0, tx}, {31'd0, f[k / CPB]});
         check("tx_busy_hi", {31'd0, tx_busy}, 32'd1);
         if (inject && k == 12) begin
            tx_byte   = 8'hFF;
            tx_enable = 1'b1;
         end
         if (inject && k == 13) tx_enable = 1'b0;
         @(posedge clk);
         #1;
      end
      check("tx_busy_lo", {31'd0, tx_busy}, 32'd0);
      check("tx_idle", {31'd0, tx}, 32'd1);
   endtask

   task automatic set_mat(input logic [7:0] x11, x12, x21, x22, y11, y12, y21, y22);
      a11 = x11; a12 = x12; a21 = x21; a22 = x22;
      b11 = y11; b12 = y12; b21 = y21; b22 = y22;
   endtask

   task automatic check_c(input string tag, input logic [7:0] e11, e12, e21, e22);
      check({tag, "_c11"}, {24'd0, c11}, {24'd0, e11});
      check({tag, "_c12"}, {24'd0, c12}, {24'd0, e12});
      check({tag, "_c21"}, {24'd0, c21}, {24'd0, e21});
      check({tag, "_c22"}, {24'd0, c22}, {24'd0, e22});
   endtask

   initial begin
      rst_n     = 1'b0;
      rx        = 1'b1;
      rx_enable = 1'b1;
      tx_enable = 1'b0;
      tx_byte   = 8'h00;
      set_mat(0, 0, 0, 0, 0, 0, 0, 0);

      // Reset with rx toggling
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         rx = ~rx;
      end
      check("rst_tx", {31'd0, tx}, 32'd1);
      check("rst_busy", {31'd0, tx_busy}, 32'd0);
      check("rst_avail", {31'd0, byte_available}, 32'd0);
      check("rst_rxbyte", {24'd0, rx_byte}, 32'd0);
      check_c("rst", 8'd0, 8'd0, 8'd0, 8'd0);
      rx    = 1'b1;
      rst_n = 1'b1;
      wait_cyc(4);
      check("post_rst_pulses", pulse_cnt, 0);

      // Back-to-back receive: 0xA5 then 0x00, zero idle bits
      send_rx(8'hA5, 1'b1);
      send_rx(8'h00, 1'b1);
      wait_cyc(8);
      check("b2b_count", pulse_cnt, 2);
      check("b2b_byte0", {24'd0, rx_log[0]}, 32'hA5);
      check("b2b_byte1", {24'd0, rx_log[1]}, 32'h00);
      check("b2b_rxbyte", {24'd0, rx_byte}, 32'h00);

      // Transmit 0x3C, with an ignored 0xFF strobe mid-frame
      tx_frame(8'h3C, 1'b1);
      wait_cyc(2);
      check("tx_no_requeue", {31'd0, tx_busy}, 32'd0);

      // Multiplier: one-cycle latency
      set_mat(1, 2, 3, 4, 5, 6, 7, 8);
      check_c("mul_pre", 8'd0, 8'd0, 8'd0, 8'd0);
      wait_cyc(1);
      check_c("mul_basic", 8'd19, 8'd22, 8'd43, 8'd50);
      set_mat(200, 200, 200, 200, 2, 2, 2, 2);
      wait_cyc(1);
      check_c("mul_ovf", 8'd32, 8'd32, 8'd32, 8'd32);
      set_mat(255, 255, 255, 255, 255, 255, 255, 255);
      wait_cyc(1);
      check_c("mul_max", 8'd2, 8'd2, 8'd2, 8'd2);
      set_mat(0, 1, 2, 0, 9, 0, 0, 7);
      wait_cyc(1);
      check_c("mul_mix", 8'd0, 8'd7, 8'd18, 8'd0);

      // One-cycle glitch
      rx = 1'b0;
      wait_cyc(1);
      rx = 1'b1;
      wait_cyc(20);
      check("glitch_count", pulse_cnt, 2);

      // Framing error
      send_rx(8'h77, 1'b0);
      rx = 1'b1;
      wait_cyc(12);
      check("ferr_count", pulse_cnt, 2);
      check("ferr_rxbyte", {24'd0, rx_byte}, 32'h00);

      // rx_enable dropped mid-frame
      fork
         send_rx(8'h55, 1'b1);
         begin
            wait_cyc(14);
            rx_enable = 1'b0;
         end
      join
      wait_cyc(8);
      rx_enable = 1'b1;
      wait_cyc(8);
      check("abort_count", pulse_cnt, 2);
      check("abort_rxbyte", {24'd0, rx_byte}, 32'h00);

      send_rx(8'h81, 1'b1);
      wait_cyc(8);
      check("recover_count", pulse_cnt, 3);
      check("recover_rxbyte", {24'd0, rx_byte}, 32'h81);

      // Full duplex
      fork
         send_rx(8'h5A, 1'b1);
         tx_frame(8'hC3, 1'b0);
      join
      wait_cyc(8);
      check("duplex_count", pulse_cnt, 4);
      check("duplex_rxbyte", {24'd0, rx_byte}, 32'h5A);

      // Reset in the middle of a transmit
      tx_byte   = 8'h00;
      tx_enable = 1'b1;
      wait_cyc(1);
      tx_enable = 1'b0;
      wait_cyc(6);
      check("midrst_pre_tx", {31'd0, tx}, 32'd0);
      check("midrst_pre_busy", {31'd0, tx_busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_tx", {31'd0, tx}, 32'd1);
      check("midrst_busy", {31'd0, tx_busy}, 32'd0);
      check("midrst_c11", {24'd0, c11}, 32'd0);
      wait_cyc(2);
      rst_n = 1'b1;
      wait_cyc(4);
      check("midrst_idle_tx", {31'd0, tx}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
